// File: rtl/gp_rf_pkg.sv
// rtl/gp_rf_pkg.sv - shared register-file widths and address/data typedefs
package gp_rf_pkg;
  localparam int GP_RF_DATA_W = 16;
  localparam int GP_RF_ADDR_W = 3;

  typedef logic [GP_RF_DATA_W-1:0] reg_data_t;
  typedef logic [GP_RF_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/gp_rf_scoreboard.sv
// rtl/gp_rf_scoreboard.sv - per-register pending bits for decode hazard detection
module gp_rf_scoreboard
  import gp_rf_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = GP_RF_ADDR_W,
  parameter int R0_ZERO  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_set_en,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr_en,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_pend
);

  logic [NUM_REGS-1:0] r_pend;
  logic                w_set_ok;

  assign w_set_ok = i_set_en && !((R0_ZERO != 0) && (i_set_addr == '0));

  // Set is applied after clear so a newly issued producer keeps the bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      if (i_clr_en) r_pend[i_clr_addr] <= 1'b0;
      if (w_set_ok) r_pend[i_set_addr] <= 1'b1;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/gp_reg_file_sb.sv
// rtl/gp_reg_file_sb.sv - register file with PC alias and scoreboard; REGFILE_BYPASS_EN adds write forwarding
module gp_reg_file_sb
  import gp_rf_pkg::*;
#(
  parameter int                DATA_W   = GP_RF_DATA_W,
  parameter int                ADDR_W   = GP_RF_ADDR_W,
  parameter int                PC_IDX   = (1 << ADDR_W) - 1,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                R0_ZERO  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_wr_en,
  input  logic [DATA_W-1:0] pc_wr_data,
  output logic [DATA_W-1:0] pc_out,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_pend;
  logic                w_wr_ok;

  assign w_wr_ok = wr_en && !((R0_ZERO != 0) && (wr_addr == '0));

  // PC write is applied last so it wins a collision on PC_IDX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
    end else begin
      if (w_wr_ok)  r_regs[wr_addr] <= wr_data;
      if (pc_wr_en) r_regs[PC_A]    <= pc_wr_data;
    end
  end

  gp_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .R0_ZERO  (R0_ZERO)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (sb_set_en),
    .i_set_addr (sb_set_addr),
    .i_clr_en   (wr_en),
    .i_clr_addr (wr_addr),
    .o_pend     (w_pend)
  );

  always_comb begin
    rd_data1 = r_regs[rd_addr1];
    rd_busy1 = w_pend[rd_addr1];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      if (!(sb_set_en && (sb_set_addr == rd_addr1))) rd_busy1 = 1'b0;
    end
    if (pc_wr_en && (rd_addr1 == PC_A)) rd_data1 = pc_wr_data;
`endif
    if ((R0_ZERO != 0) && (rd_addr1 == '0)) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = r_regs[rd_addr2];
    rd_busy2 = w_pend[rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      if (!(sb_set_en && (sb_set_addr == rd_addr2))) rd_busy2 = 1'b0;
    end
    if (pc_wr_en && (rd_addr2 == PC_A)) rd_data2 = pc_wr_data;
`endif
    if ((R0_ZERO != 0) && (rd_addr2 == '0)) rd_data2 = '0;
  end

  assign pc_out   = r_regs[PC_A];
  assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_gp_reg_file_sb.sv
// tb/tb_gp_reg_file_sb.sv - scoreboard bench for gp_reg_file_sb (R0_ZERO=1, RESET_PC=0x0040)
module tb_gp_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr, sb_set_addr, dbg_addr;
  logic [15:0] rd_data1, rd_data2, wr_data, pc_wr_data, pc_out, dbg_data;
  logic        rd_busy1, rd_busy2, wr_en, pc_wr_en, sb_set_en;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] d1;
    logic        b1;
    logic [15:0] d2;
    logic        b2;
    logic [15:0] pc;
    logic [15:0] dbg;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  gp_reg_file_sb #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .PC_IDX   (7),
    .RESET_PC (16'h0040),
    .R0_ZERO  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .rd_busy1    (rd_busy1),
    .rd_busy2    (rd_busy2),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pc_wr_en    (pc_wr_en),
    .pc_wr_data  (pc_wr_data),
    .pc_out      (pc_out),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string n, input string f, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "rd_data1", rd_data1, e.d1);
      chk(e.name, "rd_busy1", {15'b0, rd_busy1}, {15'b0, e.b1});
      chk(e.name, "rd_data2", rd_data2, e.d2);
      chk(e.name, "rd_busy2", {15'b0, rd_busy2}, {15'b0, e.b2});
      chk(e.name, "pc_out", pc_out, e.pc);
      chk(e.name, "dbg_data", dbg_data, e.dbg);
    end
  end

  task automatic expect_now(input string n, input logic [15:0] d1, input logic b1,
                            input logic [15:0] d2, input logic b2,
                            input logic [15:0] pc, input logic [15:0] dbg);
    exp_t e;
    e.name = n; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.pc = pc; e.dbg = dbg;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 1'b0; pc_wr_en = 1'b0; sb_set_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] ad);
    rd_addr1 = a1; rd_addr2 = a2; dbg_addr = ad;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic pcw(input logic [15:0] d);
    pc_wr_en = 1'b1; pc_wr_data = d;
  endtask

  task automatic sbset(input logic [2:0] a);
    sb_set_en = 1'b1; sb_set_addr = a;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pc_wr_en = 1'b0; pc_wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 3'(7 - a), 3'(a));
      expect_now($sformatf("reset_a%0d", a),
                 (a == 7) ? 16'h0040 : 16'h0000, 1'b0,
                 (a == 0) ? 16'h0040 : 16'h0000, 1'b0,
                 16'h0040,
                 (a == 7) ? 16'h0040 : 16'h0000);
      tick();
    end

    rd(3, 0, 3); wr(3, 16'hBEEF);
    expect_now("wr3_same", BYP ? 16'hBEEF : 16'h0000, 0, 0, 0, 16'h0040, 16'h0000);
    tick();
    rd(3, 0, 3);
    expect_now("wr3_next", 16'hBEEF, 0, 0, 0, 16'h0040, 16'hBEEF);
    tick();

    rd(7, 3, 7); wr(7, 16'h1111); pcw(16'h2222);
    expect_now("pc_coll_same", BYP ? 16'h2222 : 16'h0040, 0, 16'hBEEF, 0, 16'h0040, 16'h0040);
    tick();
    rd(7, 3, 7);
    expect_now("pc_coll_next", 16'h2222, 0, 16'hBEEF, 0, 16'h2222, 16'h2222);
    tick();

    rd(4, 7, 4); wr(4, 16'h1234); pcw(16'h0100);
    expect_now("dual_wr_same", BYP ? 16'h1234 : 16'h0000, 0,
               BYP ? 16'h0100 : 16'h2222, 0, 16'h2222, 16'h0000);
    tick();
    rd(4, 7, 4); sbset(5);
    expect_now("dual_wr_next", 16'h1234, 0, 16'h0100, 0, 16'h0100, 16'h1234);
    tick();

    rd(5, 4, 5); wr(5, 16'h0055);
    expect_now("sb5_set", BYP ? 16'h0055 : 16'h0000, BYP ? 1'b0 : 1'b1,
               16'h1234, 0, 16'h0100, 16'h0000);
    tick();
    rd(5, 4, 5); sbset(5); wr(5, 16'h0066);
    expect_now("sb5_cleared", BYP ? 16'h0066 : 16'h0055, 0, 16'h1234, 0, 16'h0100, 16'h0055);
    tick();
    rd(5, 5, 5); sbset(5);
    expect_now("sb5_set_wins", 16'h0066, 1, 16'h0066, 1, 16'h0100, 16'h0066);
    tick();

    rd(5, 0, 0); wr(0, 16'hFFFF); sbset(0);
    expect_now("r0_wr_same", 16'h0066, 1, 16'h0000, 0, 16'h0100, 16'h0000);
    tick();
    rd(0, 5, 0); sbset(2); wr(2, 16'h00AA);
    expect_now("r0_after", 16'h0000, 0, 16'h0066, 1, 16'h0100, 16'h0000);
    tick();

    rd(2, 5, 2); rst_n = 1'b0; wr(6, 16'h7777); sbset(6);
    expect_now("pre_reset", 16'h00AA, 1, 16'h0066, 1, 16'h0100, 16'h00AA);
    tick();
    rd(2, 6, 5);
    expect_now("post_reset_a", 16'h0000, 0, 16'h0000, 0, 16'h0040, 16'h0000);
    tick();
    rd(5, 3, 4);
    expect_now("post_reset_b", 16'h0000, 0, 16'h0000, 0, 16'h0040, 16'h0000);
    tick();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gp_reg_file_sb.md
# gp_reg_file_sb

Parametrised, clocked general-purpose register file for the pipelined core. It provides two asynchronous read ports, one general write port and a dedicated program-counter write port. A per-register pending scoreboard gives decode-stage hazard detection, and optional write-to-read forwarding is compiled in by macro. It sits between decode (reads, scoreboard set) and write-back (writes, scoreboard clear).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W
- PC_IDX, NUM_REGS-1, index of the register aliased to the program counter
- RESET_PC, 0, reset value of register PC_IDX
- R0_ZERO, 0, when 1 register 0 reads as zero and ignores writes

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data
- rd_data2  out  DATA_W  read port 2 data
- rd_busy1  out  1  pending bit of rd_addr1
- rd_busy2  out  1  pending bit of rd_addr2
- wr_en  in  1  general write strobe (write-back)
- wr_addr  in  ADDR_W  general write address
- wr_data  in  DATA_W  general write data
- pc_wr_en  in  1  PC write strobe
- pc_wr_data  in  DATA_W  PC write data
- pc_out  out  DATA_W  current PC register contents
- sb_set_en  in  1  mark destination pending (instruction issued)
- sb_set_addr  in  ADDR_W  destination to mark
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  stored contents at dbg_addr, never forwarded

## Operation
- Storage: NUM_REGS x DATA_W flops. Writes occur on the clk rising edge. Reads are combinational from storage.
- General write: when wr_en=1, reg[wr_addr] <= wr_data. This is suppressed when R0_ZERO=1 and wr_addr=0.
- PC write: when pc_wr_en=1, reg[PC_IDX] <= pc_wr_data.
- Collision: if wr_en=1, pc_wr_en=1 and wr_addr=PC_IDX in the same cycle, pc_wr_data wins.
- Collision with simultaneous writes to different registers: both writes take effect.
- Scoreboard: one pending bit per register.
  - sb_set_en sets pend[sb_set_addr].
  - wr_en clears pend[wr_addr].
  - Set and clear of the same address in the same cycle: the bit ends set (the newer producer wins).
  - Setting an already-set bit leaves it set.
  - pc_wr_en does not touch the scoreboard.
  - When R0_ZERO=1, pend[0] is never set.
- rd_busyN = pend[rd_addrN], combinational. When REGFILE_BYPASS_EN is defined and a same-cycle wr_en targets rd_addrN (and no same-cycle set), rd_busyN = 0.
- Reset (rst_n=0 at an edge):
  - all registers cleared to 0, except reg[PC_IDX] = RESET_PC
  - all pend bits cleared
  - writes and sets in that cycle are ignored
  - after that edge, every output reflects the reset state (pc_out = RESET_PC, others 0)

## Timing
- Read latency: 0 cycles (combinational from address).
- Write visibility: the new value appears on reads in the cycle after the write edge, or in the same cycle with bypass (see Configuration).
- The scoreboard bit is visible on rd_busy in the cycle after sb_set_en.
- Single clock domain; no handshakes. All inputs are sampled only at the rising edge.

## Configuration
- Macro REGFILE_BYPASS_EN.
  - Defined: when wr_en=1 and wr_addr=rd_addrN, rd_dataN = wr_data combinationally. When pc_wr_en=1 and rd_addrN=PC_IDX, rd_dataN = pc_wr_data. The PC path has priority, matching the storage collision rule. The R0_ZERO suppression still applies. pc_out stays unforwarded.
  - Undefined: reads return stored contents only, and rd_busy ignores same-cycle writes.

## Structure
- Shared package gp_rf_pkg holds the default DATA_W/ADDR_W constants and the reg_addr_t/reg_data_t typedefs, which decode and write-back also use.
- One sub-module, gp_rf_scoreboard, holds the pending-bit array with its set/clear priority and reset. The register array and bypass muxes stay in the top.

## Test plan
- Reset with RESET_PC=16'h0040 → pc_out=16'h0040; rd_data1/2=0 for all addresses; rd_busy1/2=0.
- Write reg3=16'hBEEF, read rd_addr1=3 in the next cycle → 16'hBEEF.
  - Same-cycle read: 16'hBEEF with REGFILE_BYPASS_EN defined, the previous value without it.
- wr_en to PC_IDX with 16'h1111 and pc_wr_en with 16'h2222 in the same cycle → pc_out=16'h2222.
- sb_set_en addr 5 → rd_busy1=1 for rd_addr1=5 in the next cycle.
  - wr_en addr 5 → bit cleared.
  - Set and write addr 5 in the same cycle → stays 1.
- R0_ZERO=1: write reg0=16'hFFFF and sb_set_en addr 0 → rd_data=0, rd_busy=0.
- Set pend[2] and write reg2=16'h00AA, then assert rst_n=0 for one edge → reg2=0, rd_busy=0.
